// File: rtl/count_seq_checker.sv
// Sequence checker for an up-counter bus: verifies strict +1 mod 2^CNT_W stepping,
// flags wraps and violations, and keeps saturating wrap/error tallies.
module count_seq_checker #(
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clear,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    prev_q;
    logic                locked_q;
    logic                wrap_pulse_q;
    logic [WRAP_W-1:0]   wrap_count_q;
    logic                err_pulse_q;
    logic                err_sticky_q;
    logic [ERR_W-1:0]    err_count_q;

    logic [CNT_W-1:0]    exp_c;
    logic                zero_seen_c;

    // Expected next value wraps naturally at CNT_W bits.
    assign exp_c       = prev_q + CNT_W'(1);
    assign zero_seen_c = count_valid && (count_in == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;

            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (zero_seen_c) begin
                        state_q  <= ST_TRACK;
                        prev_q   <= '0;
                        locked_q <= 1'b1;
                    end else if (!count_valid) begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (!count_valid) begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end else if (count_in == exp_c) begin
                        prev_q <= count_in;
                        if (prev_q == CNT_MAX) begin
                            wrap_pulse_q <= 1'b1;
                            if (wrap_count_q != WRAP_MAX)
                                wrap_count_q <= wrap_count_q + WRAP_W'(1);
                        end
                    end else begin
                        state_q      <= ST_ERROR;
                        prev_q       <= count_in;
                        locked_q     <= 1'b0;
                        err_pulse_q  <= 1'b1;
                        err_sticky_q <= 1'b1;
                        if (err_count_q != ERR_MAX)
                            err_count_q <= err_count_q + ERR_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase

            // Clear overrides any same-cycle tally update; pulses are unaffected.
            if (clear) begin
                wrap_count_q <= '0;
                err_count_q  <= '0;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker; outputs are packed as
// {locked, wrap_pulse, wrap_count[7:0], err_pulse, err_sticky, err_count[3:0]}.
module tb_count_seq_checker;

    logic       clk;
    logic       reset;
    logic [1:0] count_in;
    logic       count_valid;
    logic       clear;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       err_pulse;
    logic       err_sticky;
    logic [3:0] err_count;

    int tests = 0;
    int fails = 0;

    count_seq_checker #(.CNT_W(2), .WRAP_W(8), .ERR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .clear       (clear),
        .locked      (locked),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic l, input logic wp, input logic [7:0] wc,
                                       input logic ep, input logic es, input logic [3:0] ec);
        return {l, wp, wc, ep, es, ec};
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        logic [15:0] obs;
        obs = {locked, wrap_pulse, wrap_count, err_pulse, err_sticky, err_count};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply one sample, clock it, then settle past the edge.
    task automatic step(input logic v, input logic [1:0] c, input logic clr);
        count_valid = v;
        count_in    = c;
        clear       = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        count_valid = 1'b0;
        count_in    = 2'd0;
        clear       = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("por", mk(0, 0, 8'd0, 0, 0, 4'd0));
        end
        reset = 1'b0;

        // Clean stream 0,1,2,3,0,1,2,3,0
        step(1, 2'd0, 0); check("clean_lock",  mk(1, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("clean_1",     mk(1, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd2, 0);
        step(1, 2'd3, 0); check("clean_3",     mk(1, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd0, 0); check("clean_wrap1", mk(1, 1, 8'd1, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("clean_post1", mk(1, 0, 8'd1, 0, 0, 4'd0));
        step(1, 2'd2, 0);
        step(1, 2'd3, 0);
        step(1, 2'd0, 0); check("clean_wrap2", mk(1, 1, 8'd2, 0, 0, 4'd0));

        // Upstream back in reset, then skip fault 0,1,3,0,1
        step(0, 2'd0, 0); check("valid_low",   mk(0, 0, 8'd2, 0, 0, 4'd0));
        step(1, 2'd0, 0); check("skip_lock",   mk(1, 0, 8'd2, 0, 0, 4'd0));
        step(1, 2'd1, 0);
        step(1, 2'd3, 0); check("skip_err",    mk(0, 0, 8'd2, 1, 1, 4'd1));
        step(1, 2'd0, 0); check("skip_relock", mk(1, 0, 8'd2, 0, 1, 4'd1));
        step(1, 2'd1, 0); check("skip_track",  mk(1, 0, 8'd2, 0, 1, 4'd1));

        // Build wrap_count up to 5, then clear on the 3->0 edge
        step(1, 2'd2, 0);
        step(1, 2'd3, 0);
        step(1, 2'd0, 0); check("wc3", mk(1, 1, 8'd3, 0, 1, 4'd1));
        for (int k = 0; k < 2; k++) begin
            step(1, 2'd1, 0);
            step(1, 2'd2, 0);
            step(1, 2'd3, 0);
            step(1, 2'd0, 0);
        end
        check("wc5", mk(1, 1, 8'd5, 0, 1, 4'd1));
        step(1, 2'd1, 0);
        step(1, 2'd2, 0);
        step(1, 2'd3, 0); check("pre_clear",  mk(1, 0, 8'd5, 0, 1, 4'd1));
        step(1, 2'd0, 1); check("clear_wrap", mk(1, 1, 8'd0, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("post_clear", mk(1, 0, 8'd0, 0, 0, 4'd0));

        // 300 full cycles: wrap_count saturates at 255
        step(1, 2'd2, 0);
        step(1, 2'd3, 0);
        step(1, 2'd0, 0); check("sat_start", mk(1, 1, 8'd1, 0, 0, 4'd0));
        for (int k = 0; k < 299; k++) begin
            step(1, 2'd1, 0);
            step(1, 2'd2, 0);
            step(1, 2'd3, 0);
            step(1, 2'd0, 0);
            if (k == 253) check("sat_reach", mk(1, 1, 8'd255, 0, 0, 4'd0));
        end
        check("sat_hold", mk(1, 1, 8'd255, 0, 0, 4'd0));

        // Violation from TRACK, then no further pulses while in ERROR
        step(1, 2'd2, 0); check("err_enter", mk(0, 0, 8'd255, 1, 1, 4'd1));
        step(1, 2'd3, 0); check("err_stay",  mk(0, 0, 8'd255, 0, 1, 4'd1));
        step(1, 2'd1, 0); check("err_stay2", mk(0, 0, 8'd255, 0, 1, 4'd1));
        for (int k = 0; k < 17; k++) begin
            step(1, 2'd0, 0);
            step(1, 2'd2, 0);
        end
        check("err_sat", mk(0, 0, 8'd255, 1, 1, 4'd15));

        // Relock with clear, count to 7 wraps, then async reset mid-cycle
        step(1, 2'd0, 1); check("relock_clear", mk(1, 0, 8'd0, 0, 0, 4'd0));
        for (int k = 0; k < 7; k++) begin
            step(1, 2'd1, 0);
            step(1, 2'd2, 0);
            step(1, 2'd3, 0);
            step(1, 2'd0, 0);
        end
        check("wc7", mk(1, 1, 8'd7, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("wc7_locked", mk(1, 0, 8'd7, 0, 0, 4'd0));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", mk(0, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd2, 0); check("rst_hold", mk(0, 0, 8'd0, 0, 0, 4'd0));
        reset = 1'b0;
        step(1, 2'd3, 0); check("rst_idle3",  mk(0, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("rst_idle1",  mk(0, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd0, 0); check("rst_relock", mk(1, 0, 8'd0, 0, 0, 4'd0));
        step(1, 2'd1, 0); check("rst_track",  mk(1, 0, 8'd0, 0, 0, 4'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
